// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin burst scheduler sharing one async-FIFO read port
// among NUM_REQ consumers, with a one-entry output register per-owner valid/ready.
module fifo_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATASIZE   = 8,
  parameter int BURST_LEN  = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                rclk_i,
  input  logic                rrst_i,
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [NUM_REQ-1:0]  rready_i,
  input  logic                fifo_empty_i,
  input  logic [DATASIZE-1:0] fifo_rdata_i,
  output logic                ren_o,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [DATASIZE-1:0] rdata_o,
  output logic [NUM_REQ-1:0]  rvalid_o,
  output logic [NUM_REQ-1:0]  burst_done_o
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = $clog2(BURST_LEN + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [WW-1:0] BL_LAST = WW'(BURST_LEN - 1);
  localparam logic [SW-1:0] SMAX    = SW'(STARVE_MAX);
  localparam logic [PW-1:0] LAST_ID = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t              r_state, w_state_nxt;
  logic [PW-1:0]       r_ptr, r_gid, w_win, w_idx;
  logic [WW-1:0]       r_wcnt;
  logic [SW-1:0]       r_starve;
  logic [NUM_REQ-1:0]  r_gnt, r_rvalid, r_done;
  logic [DATASIZE-1:0] r_rdata;
  logic                w_any, w_slot_free, w_ren, w_grant, w_release;

  // Scan from the highest offset down so the requester closest to r_ptr wins.
  always_comb begin
    w_win = r_ptr;
    w_idx = r_ptr;
    w_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = PW'((int'(r_ptr) + k) % NUM_REQ);
      if (req_i[w_idx]) begin
        w_win = w_idx;
        w_any = 1'b1;
      end
    end
  end

  assign w_slot_free = !(|r_rvalid) || |(r_rvalid & rready_i);
  assign w_ren = (r_state == BURST) && req_i[r_gid] && !fifo_empty_i &&
                 w_slot_free && (r_wcnt <= BL_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant     = w_any && !fifo_empty_i;
        w_state_nxt = w_grant ? BURST : IDLE;
      end
      BURST: w_state_nxt = ((w_ren && r_wcnt == BL_LAST) || !req_i[r_gid] ||
                            r_starve == SMAX) ? DRAIN : BURST;
      DRAIN: begin
        w_release   = w_slot_free;
        w_state_nxt = w_slot_free ? IDLE : DRAIN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk_i or posedge rrst_i) begin
    if (rrst_i) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_gid    <= '0;
      r_ptr    <= '0;
      r_wcnt   <= '0;
      r_starve <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_done   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_release ? r_gnt : '0;
      if (w_grant) begin
        r_gnt <= NUM_REQ'(1) << w_win;
        r_gid <= w_win;
      end else if (w_release) begin
        r_gnt <= '0;
      end
      if (w_release) begin
        r_ptr    <= (r_gid == LAST_ID) ? '0 : r_gid + 1'b1;
        r_wcnt   <= '0;
        r_starve <= '0;
      end else if (w_ren) begin
        r_wcnt   <= r_wcnt + 1'b1;
        r_starve <= '0;
      end else if (r_state == BURST && fifo_empty_i && r_starve != SMAX) begin
        r_starve <= r_starve + 1'b1;
      end
      // A held word is only replaced by a read, which requires the slot to be free.
      if (w_ren) begin
        r_rdata  <= fifo_rdata_i;
        r_rvalid <= r_gnt;
      end else if (|(r_rvalid & rready_i)) begin
        r_rvalid <= '0;
      end
    end
  end

  assign ren_o        = w_ren;
  assign gnt_o        = r_gnt;
  assign rdata_o      = r_rdata;
  assign rvalid_o     = r_rvalid;
  assign burst_done_o = r_done;
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: directed stimulus with a FIFO model; a negedge monitor
// checks delivered words and burst_done pulses against scoreboard queues.
module tb_fifo_rd_arbiter;
  localparam int N = 4;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] rready = '0;
  logic         empty = 1'b1;
  logic [D-1:0] fdata = '0;
  logic         ren;
  logic [N-1:0] gnt, rvalid, done;
  logic [D-1:0] rdata;

  logic [D-1:0]   fifo_q[$];
  logic [N+D-1:0] exp_q[$];
  logic [N-1:0]   done_q[$];
  logic [N+D-1:0] m_e;
  logic           ren_q = 1'b0;
  int             n_cmp = 0;
  int             n_fail = 0;
  int             dcyc;

  fifo_rd_arbiter #(.NUM_REQ(N), .DATASIZE(D), .BURST_LEN(4), .STARVE_MAX(8)) dut (
    .rclk_i(clk), .rrst_i(rst), .req_i(req), .rready_i(rready),
    .fifo_empty_i(empty), .fifo_rdata_i(fdata), .ren_o(ren), .gnt_o(gnt),
    .rdata_o(rdata), .rvalid_o(rvalid), .burst_done_o(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req_v, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_fill(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) fifo_q.push_back(D'(base + i));
  endtask

  task automatic expect_words(input int id, input int base, input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back({N'(1 << id), D'(base + i)});
  endtask

  task automatic expect_done(input int id);
    done_q.push_back(N'(1 << id));
  endtask

  task automatic wait_drain(input string nm);
    for (int c = 0; c < 300 && (exp_q.size() != 0 || done_q.size() != 0); c++)
      @(negedge clk);
    chk(nm, 32'(exp_q.size() + done_q.size()), 0);
  endtask

  // FIFO model: pop what the DUT read at the last edge, then refresh empty/data.
  always @(posedge clk) begin
    #1;
    if (ren_q) void'(fifo_q.pop_front());
    #1;
    empty = (fifo_q.size() == 0);
    fdata = empty ? '0 : fifo_q[0];
  end

  always @(negedge clk) begin
    ren_q = ren;
    chk("ren_while_empty", 32'(ren & empty), 0);
    chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
    chk("rvalid_owner", 32'(rvalid == '0 || rvalid == gnt), 1);
    if (|(rvalid & rready)) begin
      if (exp_q.size() != 0) begin
        m_e = exp_q.pop_front();
        chk("word", 32'({rvalid, rdata}), 32'(m_e));
      end else begin
        chk("word_extra", 32'({rvalid, rdata}), 0);
      end
    end
    if (|done) begin
      if (done_q.size() != 0) chk("burst_done", 32'(done), 32'(done_q.pop_front()));
      else chk("burst_done_extra", 32'(done), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ren", 32'(ren), 0);
    step; rst = 1'b0;
    // single requester, two bursts of four back to back
    step; rready = '1; req = 4'b0001; fifo_fill(8'h10, 8);
    expect_words(0, 8'h10, 8); expect_done(0); expect_done(0);
    @(negedge clk); chk("t1_gnt_before", 32'(gnt), 0);
    @(negedge clk); chk("t1_gnt_latency", 32'(gnt), 1); chk("t1_ren", 32'(ren), 1);
    wait_drain("t1_drain");
    step; req = '0;
    step; rst = 1'b1;
    step; rst = 1'b0;
    // three requesters, round-robin order 0,1,2,0,1
    step; req = 4'b0111; fifo_fill(8'h20, 20);
    expect_words(0, 8'h20, 4); expect_words(1, 8'h24, 4); expect_words(2, 8'h28, 4);
    expect_words(0, 8'h2C, 4); expect_words(1, 8'h30, 4);
    expect_done(0); expect_done(1); expect_done(2); expect_done(0); expect_done(1);
    wait_drain("t2_drain");
    step; req = '0;
    // consumer stalls three cycles while holding word 0x41
    step; rready = 4'b0001; req = 4'b0001; fifo_fill(8'h40, 4);
    expect_words(0, 8'h40, 4); expect_done(0);
    step; step; step; rready = '0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall_ren", 32'(ren), 0);
      chk("t3_stall_rvalid", 32'(rvalid), 1);
      chk("t3_stall_rdata", 32'(rdata), 8'h41);
    end
    step; rready = 4'b0001;
    wait_drain("t3_drain");
    step; req = '0;
    // two words then starvation: pulse 13 cycles after the request
    step; req = 4'b0001; fifo_fill(8'h50, 2);
    expect_words(0, 8'h50, 2); expect_done(0);
    dcyc = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done[0] && dcyc < 0) dcyc = c;
    end
    chk("t4_starve_cut_cycle", 32'(dcyc), 13);
    wait_drain("t4_drain");
    step; req = '0;
    // id1 drops request with a word pending; id2 is granted next
    step; rready = '0; req = 4'b0110; fifo_fill(8'h60, 5);
    expect_words(1, 8'h60, 1); expect_words(2, 8'h61, 4); expect_done(1); expect_done(2);
    step; step; req = 4'b0100;
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_ren", 32'(ren), 0);
      chk("t5_pending_rvalid", 32'(rvalid), 4'b0010);
      chk("t5_pending_rdata", 32'(rdata), 8'h60);
    end
    step; rready = '1;
    wait_drain("t5_drain");
    step; req = '0;
    // asynchronous reset between edges mid-burst
    step; rready = '1; req = 4'b0001; fifo_fill(8'h70, 4);
    expect_words(0, 8'h70, 1);
    step; step; step; #2 rst = 1'b1;
    #1;
    chk("t6_rst_gnt", 32'(gnt), 0);
    chk("t6_rst_rvalid", 32'(rvalid), 0);
    chk("t6_rst_ren", 32'(ren), 0);
    chk("t6_rst_rdata", 32'(rdata), 0);
    req = 4'b0011;
    step; step; rst = 1'b0;
    expect_words(0, 8'h72, 2); expect_done(0);
    @(negedge clk); chk("t6_gnt_after_release", 32'(gnt), 0);
    @(negedge clk); chk("t6_id0_first", 32'(gnt), 1);
    wait_drain("t6_drain");
    step; req = '0;
    step;
    chk("fifo_leftover", 32'(fifo_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
